// File: rtl/haar_stage_evaluator_if.sv
// Bundles the controller, parameter ROM and classifier connections of one
// Haar cascade stage evaluator.
interface haar_stage_evaluator_if #(
  parameter int DATA_WIDTH_8  = 8,
  parameter int DATA_WIDTH_12 = 12,
  parameter int DATA_WIDTH_16 = 16,
  parameter int ADDR_WIDTH    = 12
);
  logic                       i_start;
  logic [ADDR_WIDTH-1:0]      i_base_addr;
  logic [DATA_WIDTH_16-1:0]   i_stage_threshold;
  logic                       o_mem_rd_en;
  logic [ADDR_WIDTH-1:0]      o_mem_addr;
  logic [DATA_WIDTH_8-1:0]    i_mem_data;
  logic [18*DATA_WIDTH_8-1:0] o_feature_params;
  logic                       o_params_valid;
  logic [DATA_WIDTH_12-1:0]   i_haarvalue;
  logic                       o_busy;
  logic                       o_done;
  logic                       o_pass;
  logic [DATA_WIDTH_16-1:0]   o_stage_sum;
  logic [DATA_WIDTH_8-1:0]    o_feature_count;

  // Environment side: cascade controller, ROM and classifier.
  modport master (
    output i_start, i_base_addr, i_stage_threshold, i_mem_data, i_haarvalue,
    input  o_mem_rd_en, o_mem_addr, o_feature_params, o_params_valid,
           o_busy, o_done, o_pass, o_stage_sum, o_feature_count
  );

  modport slave (
    input  i_start, i_base_addr, i_stage_threshold, i_mem_data, i_haarvalue,
    output o_mem_rd_en, o_mem_addr, o_feature_params, o_params_valid,
           o_busy, o_done, o_pass, o_stage_sum, o_feature_count
  );
endinterface

// File: rtl/haar_stage_evaluator.sv
// Evaluates one Haar cascade stage: fetches 18 parameter bytes per feature,
// accumulates classifier results and compares the sum to the stage threshold.
// Optional early exit once the sum reaches threshold: HAAR_STAGE_EARLY_EXIT_EN.
module haar_stage_evaluator #(
  parameter int DATA_WIDTH_8  = 8,
  parameter int DATA_WIDTH_12 = 12,
  parameter int DATA_WIDTH_16 = 16,
  parameter int NUM_FEATURES  = 16,
  parameter int ADDR_WIDTH    = 12
) (
  input logic clk,
  input logic reset_n,
  haar_stage_evaluator_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, DECIDE, DONE} state_t;

  state_t                            state;
  logic [4:0]                        byte_cnt;
  logic [DATA_WIDTH_8-1:0]           feat_idx;
  logic [DATA_WIDTH_16-1:0]          acc;
  logic [DATA_WIDTH_16-1:0]          thr;
  logic [17:0][DATA_WIDTH_8-1:0]     params;
  logic                              rd_en;
  logic [ADDR_WIDTH-1:0]             addr;
  logic                              params_valid;
  logic                              busy;
  logic                              done;
  logic                              pass;
  logic [DATA_WIDTH_16-1:0]          stage_sum;
  logic [DATA_WIDTH_8-1:0]           feature_count;

  logic [DATA_WIDTH_16-1:0]          acc_next;
  logic [DATA_WIDTH_8-1:0]           feat_next;
  logic                              stop_now;

  function automatic logic [DATA_WIDTH_16-1:0] sat_add(
    input logic [DATA_WIDTH_16-1:0] a,
    input logic [DATA_WIDTH_12-1:0] b
  );
    logic [DATA_WIDTH_16:0] s;
    s = {1'b0, a} + (DATA_WIDTH_16+1)'(b);
    return s[DATA_WIDTH_16] ? '1 : s[DATA_WIDTH_16-1:0];
  endfunction

  assign acc_next  = sat_add(acc, bus.i_haarvalue);
  assign feat_next = feat_idx + 1'b1;

`ifdef HAAR_STAGE_EARLY_EXIT_EN
  // Haar values are unsigned, so once the sum reaches threshold it stays there.
  assign stop_now = (feat_next == DATA_WIDTH_8'(NUM_FEATURES)) || (acc_next >= thr);
`else
  assign stop_now = (feat_next == DATA_WIDTH_8'(NUM_FEATURES));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      feat_idx      <= '0;
      acc           <= '0;
      thr           <= '0;
      params        <= '0;
      rd_en         <= 1'b0;
      addr          <= '0;
      params_valid  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      stage_sum     <= '0;
      feature_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            addr          <= bus.i_base_addr;
            thr           <= bus.i_stage_threshold;
            acc           <= '0;
            feat_idx      <= '0;
            byte_cnt      <= '0;
            rd_en         <= 1'b1;
            busy          <= 1'b1;
            pass          <= 1'b0;
            stage_sum     <= '0;
            feature_count <= '0;
            state         <= FETCH;
          end
        end
        FETCH: begin
          // ROM data lags the read strobe by one cycle, so byte k lands in cycle k+1.
          if (byte_cnt != 5'd0) params[byte_cnt - 5'd1] <= bus.i_mem_data;
          if (byte_cnt <= 5'd17) addr <= addr + 1'b1;
          rd_en <= (byte_cnt < 5'd17);
          if (byte_cnt == 5'd18) begin
            byte_cnt     <= '0;
            params_valid <= 1'b1;
            state        <= EVAL;
          end else begin
            byte_cnt <= byte_cnt + 5'd1;
          end
        end
        EVAL: begin
          params_valid <= 1'b0;
          acc          <= acc_next;
          feat_idx     <= feat_next;
          if (stop_now) begin
            state <= DECIDE;
          end else begin
            rd_en <= 1'b1;
            state <= FETCH;
          end
        end
        DECIDE: begin
          pass          <= (acc >= thr);
          stage_sum     <= acc;
          feature_count <= feat_idx;
          done          <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_mem_rd_en      = rd_en;
  assign bus.o_mem_addr       = addr;
  assign bus.o_feature_params = params;
  assign bus.o_params_valid   = params_valid;
  assign bus.o_busy           = busy;
  assign bus.o_done           = done;
  assign bus.o_pass           = pass;
  assign bus.o_stage_sum      = stage_sum;
  assign bus.o_feature_count  = feature_count;

endmodule

// File: tb/tb_haar_stage_evaluator.sv
// Directed bench for haar_stage_evaluator: a 2-feature instance for table
// vectors and reset abort, and a 17-feature instance for long/saturating stages.
module tb_haar_stage_evaluator;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  haar_stage_evaluator_if #(.ADDR_WIDTH(AW)) a_if();
  haar_stage_evaluator_if #(.ADDR_WIDTH(AW)) b_if();

  haar_stage_evaluator #(.NUM_FEATURES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a_if.slave)
  );
  haar_stage_evaluator #(.NUM_FEATURES(17)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b_if.slave)
  );

  // ROM models: byte content equals the low byte of the address.
  always @(posedge clk) if (a_if.o_mem_rd_en) a_if.i_mem_data <= a_if.o_mem_addr[7:0];
  always @(posedge clk) if (b_if.o_mem_rd_en) b_if.i_mem_data <= b_if.o_mem_addr[7:0];

  // Classifier models: per-feature value table for A, constant value for B.
  int          a_eval = 0;
  logic [11:0] a_hv [2];
  logic [11:0] b_hv = 12'd0;
  always @(posedge clk)
    if (a_if.i_start) a_eval <= 0;
    else if (a_if.o_params_valid) a_eval <= a_eval + 1;
  always_comb a_if.i_haarvalue = (a_if.o_params_valid && a_eval < 2) ? a_hv[a_eval[0]] : 12'd0;
  always_comb b_if.i_haarvalue = b_if.o_params_valid ? b_hv : 12'd0;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [11:0] base;
    logic [15:0] thr;
    logic [11:0] hv0;
    logic [11:0] hv1;
    logic        exp_pass;
    logic [15:0] exp_sum;
  } vec_t;

  function automatic logic [159:0] a_outputs();
    return {a_if.o_mem_rd_en, a_if.o_mem_addr, a_if.o_feature_params, a_if.o_params_valid,
            a_if.o_busy, a_if.o_done, a_if.o_pass, a_if.o_stage_sum, a_if.o_feature_count};
  endfunction

  task automatic run_a(input vec_t v, input string tag);
    int rd_cnt = 0, addr_err = 0, pv_cnt = 0, done_c = -1;
    logic busy0 = 1'b0, busy_d = 1'b0, pass_d = 1'b0;
    logic [15:0] sum_d = '0;
    logic [7:0] cnt_d = '0;
    logic [143:0] exp_p, got_p;
    logic [11:0] t;
    got_p = '0;
    for (int k = 0; k < 18; k++) begin
      t = v.base + 12'(k);
      exp_p[k*8 +: 8] = t[7:0];
    end
    a_if.i_base_addr = v.base;
    a_if.i_stage_threshold = v.thr;
    a_hv[0] = v.hv0;
    a_hv[1] = v.hv1;
    @(negedge clk);
    a_if.i_start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 400 && done_c < 0; c++) begin
      @(negedge clk);
      a_if.i_start = 1'b0;
      if (c == 0) busy0 = a_if.o_busy;
      if (a_if.o_mem_rd_en) begin
        if (a_if.o_mem_addr !== v.base + 12'(rd_cnt)) addr_err++;
        rd_cnt++;
      end
      if (a_if.o_params_valid) begin
        if (pv_cnt == 0) got_p = a_if.o_feature_params;
        pv_cnt++;
      end
      if (a_if.o_done) begin
        done_c = c;
        busy_d = a_if.o_busy;
        pass_d = a_if.o_pass;
        sum_d  = a_if.o_stage_sum;
        cnt_d  = a_if.o_feature_count;
      end
    end
    check({tag, "_busy_start"}, busy0, 1);
    check({tag, "_done_cycle"}, done_c, 41);
    check({tag, "_rd_count"}, rd_cnt, 36);
    check({tag, "_rd_addr_errors"}, addr_err, 0);
    check({tag, "_params_f0"}, got_p, exp_p);
    check({tag, "_valid_cycles"}, pv_cnt, 2);
    check({tag, "_busy_at_done"}, busy_d, 1);
    check({tag, "_pass"}, pass_d, v.exp_pass);
    check({tag, "_sum"}, sum_d, v.exp_sum);
    check({tag, "_count"}, cnt_d, 2);
    @(negedge clk);
    check({tag, "_done_pulse"}, a_if.o_done, 0);
    check({tag, "_busy_after"}, a_if.o_busy, 0);
    check({tag, "_sum_held"}, a_if.o_stage_sum, v.exp_sum);
  endtask

  task automatic run_b(input logic [15:0] thr, input logic [11:0] hv, input int exp_done,
                       input logic [15:0] exp_sum, input int exp_cnt, input string tag);
    int done_c = -1;
    logic pass_d = 1'b0;
    logic [15:0] sum_d = '0;
    logic [7:0] cnt_d = '0;
    b_if.i_base_addr = 12'd7;
    b_if.i_stage_threshold = thr;
    b_hv = hv;
    @(negedge clk);
    b_if.i_start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 800 && done_c < 0; c++) begin
      @(negedge clk);
      b_if.i_start = 1'b0;
      if (b_if.o_done) begin
        done_c = c;
        pass_d = b_if.o_pass;
        sum_d  = b_if.o_stage_sum;
        cnt_d  = b_if.o_feature_count;
      end
    end
    check({tag, "_done_cycle"}, done_c, exp_done);
    check({tag, "_pass"}, pass_d, 1);
    check({tag, "_sum"}, sum_d, exp_sum);
    check({tag, "_count"}, cnt_d, exp_cnt);
  endtask

  vec_t vecs [5];

  initial begin
    logic busy_pre;
    logic seen_done;
    vecs[0] = '{base: 12'd0,    thr: 16'd150,  hv0: 12'd100,  hv1: 12'd50,   exp_pass: 1'b1, exp_sum: 16'd150};
    vecs[1] = '{base: 12'd0,    thr: 16'd151,  hv0: 12'd100,  hv1: 12'd50,   exp_pass: 1'b0, exp_sum: 16'd150};
    vecs[2] = '{base: 12'd4090, thr: 16'd20,   hv0: 12'd7,    hv1: 12'd9,    exp_pass: 1'b0, exp_sum: 16'd16};
    vecs[3] = '{base: 12'd100,  thr: 16'd8190, hv0: 12'd4095, hv1: 12'd4095, exp_pass: 1'b1, exp_sum: 16'd8190};
    vecs[4] = '{base: 12'd2000, thr: 16'd1,    hv0: 12'd0,    hv1: 12'd0,    exp_pass: 1'b0, exp_sum: 16'd0};

    a_if.i_start = 1'b0; a_if.i_base_addr = '0; a_if.i_stage_threshold = '0;
    b_if.i_start = 1'b0; b_if.i_base_addr = '0; b_if.i_stage_threshold = '0;
    a_hv[0] = '0; a_hv[1] = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", a_outputs(), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_a(vecs[i], $sformatf("vec%0d", i));

    // Abort in the middle of feature 1 fetch, then restart cleanly.
    a_if.i_base_addr = 12'd0;
    a_if.i_stage_threshold = 16'd150;
    a_hv[0] = 12'd100; a_hv[1] = 12'd50;
    @(negedge clk);
    a_if.i_start = 1'b1;
    @(posedge clk);
    repeat (26) begin
      @(negedge clk);
      a_if.i_start = 1'b0;
    end
    busy_pre = a_if.o_busy;
    check("abort_busy_before", busy_pre, 1);
    #2 reset_n = 1'b0;
    #1 check("abort_outputs_zero", a_outputs(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (a_if.o_done || a_if.o_busy) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    run_a(vecs[0], "restart");

`ifdef HAAR_STAGE_EARLY_EXIT_EN
    run_b(16'd300, 12'd200, 41, 16'd400, 2, "early");
`else
    run_b(16'd300, 12'd200, 341, 16'd3400, 17, "full");
`endif
    run_b(16'hFFFF, 12'd4095, 341, 16'hFFFF, 17, "saturate");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
